// File: rtl/modred_pm_pipe.sv
// modred_pm_pipe: three-stage pipelined reducer of a 2W-bit dividend modulo the
// pseudo-Mersenne prime p = 2^W - C. Produces remainder (< p) and, optionally,
// the full W+1-bit quotient floor(dividend / p).
//
// Stages: S1 folds the high half (hi*C + lo), S2 folds the small overflow again,
// S3 applies up to two conditional subtractions of p.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready is a combinational ready chain)
//   dividend, in_tag      2W-bit operand and opaque sideband
//   out_valid/out_ready   output handshake; outputs held while stalled
//   quotient, remainder   floor(dividend/p), dividend mod p
//   out_tag               in_tag of the same transaction
//
// Optional feature macro: MODRED_QUOT_EN. When defined the quotient datapath is
// built; when undefined the quotient port is tied to 0.
module modred_pm_pipe #(
   parameter int unsigned W     = 32,
   parameter int unsigned C     = 5,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*W-1:0]   dividend,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W:0]       quotient,
   output logic [W-1:0]     remainder,
   output logic [TAG_W-1:0] out_tag
);

   // Width of the overflow above bit W after the first fold.
   localparam int unsigned HW  = $clog2(C) + 2;
   localparam int unsigned S1W = W + HW;
   localparam logic [W:0]  P   = {1'b1, {W{1'b0}}} - (W+1)'(C);

   // Keeps the fold widths overflow-free and two corrections sufficient.
   if (C < 1 || C >= (32'd1 << (W/2 - 1))) begin : g_bad_c
      $error("modred_pm_pipe: C out of legal range");
   end

   logic             rdy1, rdy2, rdy3;
   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [S1W-1:0]   s1_q, s1_d;
   logic [W:0]       s2_q, s2_d;
   logic [W-1:0]     r3_q, r3_d;
   logic [TAG_W-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
   logic [HW-1:0]    h2;
   logic [W-1:0]     l2;
   logic             c_a, c_b;
   logic [W:0]       corr_a, corr_b;

   always_comb begin
      rdy3     = !v3_q || out_ready;
      rdy2     = !v2_q || rdy3;
      rdy1     = !v1_q || rdy2;
      in_ready = rdy1;
   end

   always_comb begin
      v1_d = v1_q;
      v2_d = v2_q;
      v3_d = v3_q;
      s1_d = s1_q;
      s2_d = s2_q;
      r3_d = r3_q;
      t1_d = t1_q;
      t2_d = t2_q;
      t3_d = t3_q;

      h2 = s1_q[S1W-1:W];
      l2 = s1_q[W-1:0];

      // s2 < 2^W + C^2 < 3p, so two subtractions always land below p.
      c_a    = (s2_q >= P);
      corr_a = c_a ? (s2_q - P) : s2_q;
      c_b    = (corr_a >= P);
      corr_b = c_b ? (corr_a - P) : corr_a;

      if (rdy1) begin
         v1_d = in_valid;
         if (in_valid) begin
            s1_d = S1W'(dividend[2*W-1:W]) * S1W'(C) + S1W'(dividend[W-1:0]);
            t1_d = in_tag;
         end
      end
      if (rdy2) begin
         v2_d = v1_q;
         if (v1_q) begin
            s2_d = (W+1)'(h2) * (W+1)'(C) + (W+1)'(l2);
            t2_d = t1_q;
         end
      end
      if (rdy3) begin
         v3_d = v2_q;
         if (v2_q) begin
            r3_d = W'(corr_b);
            t3_d = t2_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
         r3_q <= '0;
         t1_q <= '0;
         t2_q <= '0;
         t3_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         r3_q <= r3_d;
         t1_q <= t1_d;
         t2_q <= t2_d;
         t3_q <= t3_d;
      end
   end

`ifdef MODRED_QUOT_EN
   logic [W-1:0] q1_q, q1_d;
   logic [W:0]   q2_q, q2_d, q3_q, q3_d;

   always_comb begin
      q1_d = q1_q;
      q2_d = q2_q;
      q3_d = q3_q;
      if (rdy1 && in_valid) q1_d = dividend[2*W-1:W];
      if (rdy2 && v1_q)     q2_d = (W+1)'(q1_q) + (W+1)'(h2);
      if (rdy3 && v2_q)     q3_d = q2_q + (W+1)'(c_a) + (W+1)'(c_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1_q <= '0;
         q2_q <= '0;
         q3_q <= '0;
      end else begin
         q1_q <= q1_d;
         q2_q <= q2_d;
         q3_q <= q3_d;
      end
   end

   assign quotient = q3_q;
`else
   assign quotient = '0;
`endif

   assign out_valid = v3_q;
   assign remainder = r3_q;
   assign out_tag   = t3_q;

endmodule

// File: tb/tb_modred_pm_pipe.sv
// Testbench for modred_pm_pipe (W=32, C=5). Expected results come from plain
// 64-bit division/modulo and an in-order queue of outstanding transactions.
module tb_modred_pm_pipe;

   localparam int unsigned W     = 32;
   localparam int unsigned C     = 5;
   localparam int unsigned TAG_W = 4;
   localparam logic [63:0] P64   = 64'd4294967291;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      dividend;
   logic [3:0]       in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [32:0]      quotient;
   logic [31:0]      remainder;
   logic [3:0]       out_tag;

   always #5 clk = ~clk;

   modred_pm_pipe #(
      .W     (W),
      .C     (C),
      .TAG_W (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .out_tag   (out_tag)
   );

   typedef struct packed {
      logic [32:0] q;
      logic [31:0] r;
      logic [3:0]  t;
   } exp_t;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   function automatic exp_t golden(input logic [63:0] x, input logic [3:0] t);
      exp_t        e;
      logic [63:0] qq;
      logic [63:0] rr;
      qq  = x / P64;
      rr  = x % P64;
      e.q = qq[32:0];
      e.r = rr[31:0];
      e.t = t;
`ifndef MODRED_QUOT_EN
      e.q = '0;
`endif
      return e;
   endfunction

   // Drives one cycle's inputs at the falling edge and reports whether the
   // next rising edge will perform an input and/or output transfer.
   task automatic drive_cycle(input logic iv, input logic [63:0] d, input logic [3:0] t,
                              input logic ordy, output logic acc, output logic dlv);
      @(negedge clk);
      in_valid  = iv;
      dividend  = d;
      in_tag    = t;
      out_ready = ordy;
      #1;
      acc = iv && in_ready;
      dlv = out_valid && ordy;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      dividend  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({out_valid, quotient, remainder, out_tag} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b q=%0d r=%0d tag=%0d, expected all 0",
                  out_valid, quotient, remainder, out_tag);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [63:0] vals [4];
      logic        acc, dlv;
      int          lat;
      exp_t        e;
      vals[0] = 64'd0;
      vals[1] = 64'd4294967291;
      vals[2] = 64'd4294967290;
      vals[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         e = golden(vals[i], 4'(i));
         drive_cycle(1'b1, vals[i], 4'(i), 1'b1, acc, dlv);
         n_cmp++;
         if (acc !== 1'b1) begin
            n_err++;
            $display("FAIL directed_accept[%0d]: got %b, expected 1", i, acc);
         end
         lat = 0;
         for (int k = 1; k <= 10; k++) begin
            drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, acc, dlv);
            if (out_valid === 1'b1) begin
               lat = k;
               break;
            end
         end
         n_cmp++;
         if (lat != 3) begin
            n_err++;
            $display("FAIL directed_latency[%0d]: got %0d cycles, expected 3", i, lat);
         end
         n_cmp++;
         if ({quotient, remainder, out_tag} !== {e.q, e.r, e.t}) begin
            n_err++;
            $display("FAIL directed_value[%0d]: got q=%0d r=%0d tag=%0d, expected q=%0d r=%0d tag=%0d",
                     i, quotient, remainder, out_tag, e.q, e.r, e.t);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic        acc, dlv, ordy, iv, held, saw_stall;
      logic [63:0] x;
      logic [69:0] held_val;
      int          sent, got;
      exp_t        e;
      sb.delete();
      sent      = 0;
      got       = 0;
      held      = 1'b0;
      held_val  = '0;
      saw_stall = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         ordy = !(cyc >= 4 && cyc <= 8);
         iv   = (sent < 8);
         x    = {$urandom, $urandom};
         drive_cycle(iv, x, 4'(sent), ordy, acc, dlv);
         if (iv && !in_ready) saw_stall = 1'b1;
         if (held) begin
            n_cmp++;
            if ({out_valid, quotient, remainder, out_tag} !== held_val) begin
               n_err++;
               $display("FAIL b2b_stable: got %h, expected held %h",
                        {out_valid, quotient, remainder, out_tag}, held_val);
            end
         end
         held     = out_valid && !ordy;
         held_val = {out_valid, quotient, remainder, out_tag};
         if (dlv) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            n_cmp++;
            if ({quotient, remainder, out_tag} !== {e.q, e.r, 4'(got)}) begin
               n_err++;
               $display("FAIL b2b_out[%0d]: got q=%0d r=%0d tag=%0d, expected q=%0d r=%0d tag=%0d",
                        got, quotient, remainder, out_tag, e.q, e.r, got);
            end
            got++;
         end
         if (acc) begin
            sb.push_back(golden(x, 4'(sent)));
            sent++;
         end
      end
      n_cmp++;
      if (saw_stall !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_in_ready_drop: got %b, expected 1", saw_stall);
      end
      n_cmp++;
      if (got != 8 || sb.size() != 0) begin
         n_err++;
         $display("FAIL b2b_count: got %0d delivered, %0d pending, expected 8 and 0",
                  got, sb.size());
      end
   endtask

   task automatic test_reset_inflight();
      logic acc, dlv;
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, {$urandom, $urandom}, 4'(i), 1'b0, acc, dlv);
         n_cmp++;
         if (acc !== 1'b1) begin
            n_err++;
            $display("FAIL inflight_accept[%0d]: got %b, expected 1", i, acc);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL inflight_full: got out_valid=%b, expected 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL inflight_reset_now: got out_valid=%b, expected 0", out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive_cycle(1'b0, 64'd0, 4'd0, 1'b1, acc, dlv);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL inflight_ghost[%0d]: got out_valid=%b tag=%0d, expected 0",
                     k, out_valid, out_tag);
         end
      end
   endtask

   task automatic test_random();
      logic        acc, dlv, iv, ordy;
      logic [63:0] x;
      logic [3:0]  t;
      int          sent, got, cyc;
      exp_t        e;
      sb.delete();
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 10000 && cyc < 40000) begin
         iv   = (sent < 10000) && ($urandom_range(0, 3) != 0);
         ordy = 1'($urandom_range(0, 1));
         t    = 4'($urandom);
         case ($urandom_range(0, 7))
            0:       x = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 1023));
            1:       x = 64'($urandom) * P64 + 64'($urandom_range(0, 6));
            default: x = {$urandom, $urandom};
         endcase
         drive_cycle(iv, x, t, ordy, acc, dlv);
         if (dlv) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            n_cmp++;
            if ({quotient, remainder, out_tag} !== {e.q, e.r, e.t}) begin
               n_err++;
               $display("FAIL random[%0d]: got q=%0d r=%0d tag=%0d, expected q=%0d r=%0d tag=%0d",
                        got, quotient, remainder, out_tag, e.q, e.r, e.t);
            end
            got++;
         end
         if (acc) begin
            sb.push_back(golden(x, t));
            sent++;
         end
         cyc++;
      end
      n_cmp++;
      if (got != 10000) begin
         n_err++;
         $display("FAIL random_count: got %0d results, expected 10000", got);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_inflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
